kc705_top: RTL and testbench

KC705_TOP -- requirements
Module: kc705_top

---
 rtl/kc705_pkg.sv | 34 +++
 rtl/kc705_top_prbs7_checker.sv | 136 +++++++++++++
 rtl/kc705_top.sv | 140 ++++++++++++++
 tb/tb_kc705_top.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kc705_pkg.sv
// kc705_pkg -- shared constants and types for the KC705 PRBS7 loopback design.
//   LFSR width, seed and feedback taps, default lock thresholds, the error
//   counter width, push-button indices and the lock-state enum.
package kc705_pkg;

  localparam int                LFSR_W    = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h7F;
  // x^7 + x^6 + 1: feedback from the two oldest bits of the history.
  localparam int                TAP_HI    = 6;
  localparam int                TAP_LO    = 5;

  localparam int DEF_LOCK_GOOD  = 32;
  localparam int DEF_UNLOCK_BAD = 4;
  localparam int ERR_W          = 16;

  // Bit positions of the buttons inside the synchronizer vector.
  localparam int BTN_N   = 0;
  localparam int BTN_S   = 1;
  localparam int BTN_W   = 2;
  localparam int BTN_E   = 3;
  localparam int BTN_C   = 4;
  localparam int NUM_BTN = 5;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Next PRBS7 bit from a 7-bit history whose bit 0 is the newest bit.
  function automatic logic prbs7_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

endpackage

// File: rtl/kc705_top_prbs7_checker.sv
// prbs7_checker -- self-synchronizing PRBS7 receive checker.
//   clk_156    : system clock, rising edge
//   rst_n      : asynchronous active-low reset (already release-synchronized)
//   rx_serial  : raw serial receive bit, registered once here
//   clear      : one-cycle pulse, clears error counter and sticky flag
//   resync     : one-cycle pulse, forces HUNT and restarts qualification
//   locked     : lock FSM is in LOCKED
//   err_cnt    : saturating count of errors seen while LOCKED
//   err_sticky : set by any counted error, cleared only by clear
module prbs7_checker
  import kc705_pkg::*;
#(
  parameter int LOCK_GOOD  = DEF_LOCK_GOOD,
  parameter int UNLOCK_BAD = DEF_UNLOCK_BAD
) (
  input  logic             clk_156,
  input  logic             rst_n,
  input  logic             rx_serial,
  input  logic             clear,
  input  logic             resync,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam int QW = $clog2(LFSR_W + 1);

  logic              rx_q;
  logic [LFSR_W-1:0] r;
  logic [QW-1:0]     qual_cnt;
  lock_state_t       state, state_next;
  logic [GW-1:0]     good_cnt, good_next;
  logic [BW-1:0]     bad_cnt, bad_next;
  logic              qualified, predicted, bit_err, bit_good, count_err;

  // The prediction is only meaningful once r holds seven received bits.
  assign predicted = prbs7_fb(r);
  assign qualified = (qual_cnt == QW'(LFSR_W));
  assign bit_err   = qualified & (rx_q != predicted);
  assign bit_good  = qualified & (rx_q == predicted);
  assign count_err = bit_err & (state == LOCKED);
  assign locked    = (state == LOCKED);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk_156 or negedge rst_n) begin
    if (!rst_n) begin
      rx_q     <= 1'b0;
      r        <= '0;
      qual_cnt <= '0;
    end else begin
      rx_q <= rx_serial;
      r    <= {r[LFSR_W-2:0], rx_q};
      if (resync)          qual_cnt <= '0;
      else if (!qualified) qual_cnt <= qual_cnt + QW'(1);
    end
  end

  always_ff @(posedge clk_156 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      bad_cnt  <= bad_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    if (resync) begin
      state_next = HUNT;
      good_next  = '0;
      bad_next   = '0;
    end else begin
      unique case (state)
        HUNT: begin
          bad_next = '0;
          if (bit_err) begin
            good_next = '0;
          end else if (bit_good) begin
            if (good_cnt == GW'(LOCK_GOOD - 1)) begin
              state_next = LOCKED;
              good_next  = '0;
            end else begin
              good_next = good_cnt + GW'(1);
            end
          end
        end
        LOCKED: begin
          if (bit_err) begin
            good_next = '0;
            if (bad_cnt == BW'(UNLOCK_BAD - 1)) begin
              state_next = HUNT;
              bad_next   = '0;
            end else begin
              bad_next = bad_cnt + BW'(1);
            end
          end else if (bit_good) begin
            // A full clean run forgives earlier isolated errors.
            if (good_cnt == GW'(LOCK_GOOD - 1)) begin
              good_next = '0;
              bad_next  = '0;
            end else begin
              good_next = good_cnt + GW'(1);
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Clear has priority, so an error landing in the clear cycle is dropped.
  always_ff @(posedge clk_156 or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clear) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (count_err) begin
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/kc705_top.sv
// kc705_top -- PRBS7 serial loopback tester for the KC705 board.
//   clk_156          : 156.25 MHz clock, all logic on its rising edge
//   sys_rst_n        : asynchronous active-low reset
//   xphy_txp/txn     : PRBS7 serial transmit pair (txn = ~txp)
//   xphy_rxp/rxn     : serial receive pair, only rxp is checked
//   sfp_tx_disable   : optical transmitter disable (high = off)
//   button_n/s/w/e/c : asynchronous push buttons, active high
//   dipsw[3:0]       : [0] tx disable, [1] button_n error inject, [3:2] nibble select
//   led[7:0]         : {err nibble, heartbeat, tx on, sticky error, locked}
//   user_sma_gpio_p/n: heartbeat pair
module kc705_top
  import kc705_pkg::*;
#(
  parameter int LOCK_GOOD  = DEF_LOCK_GOOD,
  parameter int UNLOCK_BAD = DEF_UNLOCK_BAD,
  parameter int HB_BITS    = 24
) (
  input  logic       clk_156,
  input  logic       sys_rst_n,
  output logic       xphy_txp,
  output logic       xphy_txn,
  input  logic       xphy_rxp,
  input  logic       xphy_rxn,
  output logic       sfp_tx_disable,
  input  logic       button_n,
  input  logic       button_s,
  input  logic       button_w,
  input  logic       button_e,
  input  logic       button_c,
  input  logic [3:0] dipsw,
  output logic [7:0] led,
  output logic       user_sma_gpio_p,
  output logic       user_sma_gpio_n
);

  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [NUM_BTN-1:0] btn_raw, btn_meta, btn_sync, btn_prev, btn_pulse;
  logic               tx_dis, tx_en, txp_q, inj_pend, fb;
  logic [LFSR_W-1:0]  lfsr;
  logic [HB_BITS-1:0] hb_cnt;
  logic               locked, err_sticky;
  logic [ERR_W-1:0]   err_cnt;
  logic [3:0]         err_nib;
  logic               unused_inputs;

  // NOTE: reset asserts asynchronously but releases through two flops, so
  // every flop below leaves reset on the same clock edge.
  always_ff @(posedge clk_156 or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Two-flop synchronizer plus rising-edge detector for every button.
  assign btn_raw   = {button_c, button_e, button_w, button_s, button_n};
  assign btn_pulse = btn_sync & ~btn_prev;

  always_ff @(posedge clk_156 or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  // West/east buttons and the negative receive leg have no function.
  assign unused_inputs = ^{xphy_rxn, btn_pulse[BTN_W], btn_pulse[BTN_E]};

  // Transmit generator; the registered disable gates both LFSR and output.
  assign tx_en = ~tx_dis;
  assign fb    = prbs7_fb(lfsr);

  always_ff @(posedge clk_156 or negedge rst_n) begin
    if (!rst_n) begin
      tx_dis   <= 1'b1;
      lfsr     <= LFSR_SEED;
      txp_q    <= 1'b0;
      inj_pend <= 1'b0;
    end else begin
      tx_dis <= dipsw[0];
      // A request waits here until a bit actually goes out, then flips it.
      if (btn_pulse[BTN_N] && dipsw[1]) inj_pend <= 1'b1;
      else if (tx_en)                   inj_pend <= 1'b0;
      if (tx_en) begin
        lfsr  <= {lfsr[LFSR_W-2:0], fb};
        txp_q <= fb ^ inj_pend;
      end else begin
        txp_q <= 1'b0;
      end
    end
  end

  assign xphy_txp       = txp_q;
  assign xphy_txn       = ~txp_q;
  assign sfp_tx_disable = tx_dis;

  prbs7_checker #(
    .LOCK_GOOD  (LOCK_GOOD),
    .UNLOCK_BAD (UNLOCK_BAD)
  ) u_checker (
    .clk_156    (clk_156),
    .rst_n      (rst_n),
    .rx_serial  (xphy_rxp),
    .clear      (btn_pulse[BTN_C]),
    .resync     (btn_pulse[BTN_S]),
    .locked     (locked),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  always_ff @(posedge clk_156 or negedge rst_n) begin
    if (!rst_n) hb_cnt <= '0;
    else        hb_cnt <= hb_cnt + HB_BITS'(1);
  end

  assign user_sma_gpio_p = hb_cnt[HB_BITS-1];
  assign user_sma_gpio_n = ~hb_cnt[HB_BITS-1];

  always_comb begin
    err_nib = err_cnt[3:0];
    unique case (dipsw[3:2])
      2'b00: err_nib = err_cnt[3:0];
      2'b01: err_nib = err_cnt[7:4];
      2'b10: err_nib = err_cnt[11:8];
      2'b11: err_nib = err_cnt[15:12];
      default: err_nib = err_cnt[3:0];
    endcase
  end

  always_ff @(posedge clk_156 or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else        led <= {err_nib, hb_cnt[HB_BITS-1], ~tx_dis, err_sticky, locked};
  end

endmodule

// File: tb/tb_kc705_top.sv
module tb_kc705_top;

  logic clk_156 = 1'b0;
  always #5 clk_156 = ~clk_156;

  // Main instance: loopback through a force mux, short heartbeat.
  logic       sys_rst_n, txp, txn, rxp, rxn, tx_dis, gpio_p, gpio_n;
  logic [4:0] btn;
  logic [3:0] dipsw;
  logic [7:0] led;
  logic       rx_force_en;

  assign rxp = rx_force_en ? 1'b0 : txp;
  assign rxn = ~rxp;

  kc705_top #(.LOCK_GOOD(32), .UNLOCK_BAD(4), .HB_BITS(6)) dut (
    .clk_156         (clk_156),
    .sys_rst_n       (sys_rst_n),
    .xphy_txp        (txp),
    .xphy_txn        (txn),
    .xphy_rxp        (rxp),
    .xphy_rxn        (rxn),
    .sfp_tx_disable  (tx_dis),
    .button_n        (btn[0]),
    .button_s        (btn[1]),
    .button_w        (btn[2]),
    .button_e        (btn[3]),
    .button_c        (btn[4]),
    .dipsw           (dipsw),
    .led             (led),
    .user_sma_gpio_p (gpio_p),
    .user_sma_gpio_n (gpio_n)
  );

  // Saturation instance: lock tolerance large enough to stay locked while
  // a constant-one receive stream errors on every bit.
  logic       s_rst_n, s_txp, s_rxp, s_tx_dis, s_force, s_btn;
  logic       unused_s_txn, unused_s_gp, unused_s_gn;
  logic [3:0] s_dipsw;
  logic [7:0] s_led;

  assign s_rxp = s_force ? 1'b1 : s_txp;

  kc705_top #(.LOCK_GOOD(32), .UNLOCK_BAD(100000), .HB_BITS(8)) dut_sat (
    .clk_156         (clk_156),
    .sys_rst_n       (s_rst_n),
    .xphy_txp        (s_txp),
    .xphy_txn        (unused_s_txn),
    .xphy_rxp        (s_rxp),
    .xphy_rxn        (~s_rxp),
    .sfp_tx_disable  (s_tx_dis),
    .button_n        (s_btn),
    .button_s        (s_btn),
    .button_w        (s_btn),
    .button_e        (s_btn),
    .button_c        (s_btn),
    .dipsw           (s_dipsw),
    .led             (s_led),
    .user_sma_gpio_p (unused_s_gp),
    .user_sma_gpio_n (unused_s_gn)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_156);
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    cyc(3);
    btn[idx] = 1'b0;
    cyc(3);
  endtask

  task automatic wait_led0(input bit sat, input logic val, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_156);
      if ((sat ? s_led[0] : led[0]) === val) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Reads the 16-bit error counter through the LED nibble mux.
  task automatic read_cnt(input bit sat, output logic [15:0] v);
    v = '0;
    for (int sel = 0; sel < 4; sel++) begin
      if (sat) s_dipsw[3:2] = 2'(sel);
      else     dipsw[3:2]   = 2'(sel);
      cyc(2);
      v[sel*4 +: 4] = sat ? s_led[7:4] : led[7:4];
    end
    if (sat) s_dipsw[3:2] = 2'b00;
    else     dipsw[3:2]   = 2'b00;
    cyc(2);
  endtask

  typedef struct {
    logic [3:0] dip;
    logic [7:0] led_exp;
    logic [7:0] led_mask;
    logic       txdis_exp;
  } vec_t;

  task automatic main_test();
    vec_t        vt[5];
    logic [0:59] txh;
    bit          mdl[1:40];
    logic [6:0]  s;
    logic [6:0]  h;
    logic [11:0] w;
    logic [15:0] cnt;
    int          lock_at, first_one, mism, per, ones;
    bit          forced, toggled;
    logic        g;

    // Counter holds 3 after the single injected bit; led[3] is the heartbeat.
    vt[0] = '{4'b0010, 8'h37, 8'hF7, 1'b0};
    vt[1] = '{4'b0110, 8'h07, 8'hF7, 1'b0};
    vt[2] = '{4'b1010, 8'h07, 8'hF7, 1'b0};
    vt[3] = '{4'b1110, 8'h07, 8'hF7, 1'b0};
    vt[4] = '{4'b0000, 8'h37, 8'hF7, 1'b0};

    s = 7'h7F;
    for (int j = 1; j <= 40; j++) begin
      mdl[j] = s[6] ^ s[5];
      s      = {s[5:0], s[6] ^ s[5]};
    end

    sys_rst_n = 1'b0; dipsw = 4'b0000; btn = '0; rx_force_en = 1'b0;
    cyc(3);
    check("rst txp", 32'(txp), 32'd0);
    check("rst txn", 32'(txn), 32'd1);
    check("rst sfp_tx_disable", 32'(tx_dis), 32'd1);
    check("rst led", 32'(led), 32'd0);
    check("rst gpio_p", 32'(gpio_p), 32'd0);
    check("rst gpio_n", 32'(gpio_n), 32'd1);

    sys_rst_n = 1'b1;
    lock_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_156);
      txh[i] = txp;
      if (lock_at < 0 && led[0] === 1'b1) lock_at = i + 1;
    end
    check("lock within 50", 32'(lock_at > 0 && lock_at <= 50), 32'd1);
    check("led1 clean after lock", 32'(led[1]), 32'd0);
    check("led2 tx on", 32'(led[2]), 32'd1);
    check("sfp_tx_disable low", 32'(tx_dis), 32'd0);

    // Seed 7F gives six zeros then a one; compare the stream from that one.
    first_one = -1;
    for (int i = 0; i < 60; i++) if (first_one < 0 && txh[i] === 1'b1) first_one = i;
    check("prbs first one seen", 32'(first_one >= 0 && first_one < 30), 32'd1);
    mism = 0;
    if (first_one >= 0 && first_one < 30)
      for (int k = 0; k < 20; k++) if (txh[first_one + k] !== mdl[7 + k]) mism++;
    check("prbs sequence mismatches", 32'(mism), 32'd0);

    read_cnt(1'b0, cnt);
    check("err count zero after lock", 32'(cnt), 32'd0);

    g = gpio_p; toggled = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_156);
      if (gpio_p !== g) begin toggled = 1'b1; break; end
    end
    g = gpio_p; per = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_156);
      per++;
      if (gpio_p !== g) break;
    end
    check("heartbeat half period", 32'(toggled ? per : 0), 32'd32);

    press(2); press(3); cyc(10);
    read_cnt(1'b0, cnt);
    check("w/e ignored count", 32'(cnt), 32'd0);
    check("w/e ignored lock", 32'(led[0]), 32'd1);

    press(0); cyc(15);
    read_cnt(1'b0, cnt);
    check("button_n ignored without dipsw1", 32'(cnt), 32'd0);
    check("no sticky without dipsw1", 32'(led[1]), 32'd0);

    dipsw = 4'b0010;
    press(0); cyc(20);
    for (int i = 0; i < 5; i++) begin
      dipsw = vt[i].dip;
      cyc(2);
      check($sformatf("table[%0d] led", i), 32'(led & vt[i].led_mask), 32'(vt[i].led_exp));
      check($sformatf("table[%0d] sfp_tx_disable", i), 32'(tx_dis), 32'(vt[i].txdis_exp));
    end

    press(4); cyc(3);
    read_cnt(1'b0, cnt);
    check("count after clear", 32'(cnt), 32'd0);
    check("sticky after clear", 32'(led[1]), 32'd0);
    check("lock kept after clear", 32'(led[0]), 32'd1);

    // Force zeros where the seven-bit window around the cut holds at least
    // four ones, so the self-sync checker sees enough errors to drop lock.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_156);
      h = {h[5:0], txp};
    end
    forced = 1'b0;
    for (int i = 0; i < 300 && !forced; i++) begin
      @(negedge clk_156);
      h = {h[5:0], txp};
      for (int k = 0; k < 7; k++) w[k] = h[6-k];
      for (int k = 7; k < 12; k++) w[k] = w[k-7] ^ w[k-6];
      ones = 0;
      for (int k = 5; k < 12; k++) ones += int'(w[k]);
      if (ones >= 4) begin
        rx_force_en = 1'b1;
        forced      = 1'b1;
      end
    end
    check("force point found", 32'(forced), 32'd1);
    wait_led0(1'b0, 1'b0, 20, "unlock on rx zero");
    rx_force_en = 1'b0;
    wait_led0(1'b0, 1'b1, 50, "relock after release");

    press(1);
    check("button_s forces hunt", 32'(led[0]), 32'd0);
    wait_led0(1'b0, 1'b1, 50, "relock after button_s");

    @(negedge clk_156);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async rst txp", 32'(txp), 32'd0);
    check("async rst txn", 32'(txn), 32'd1);
    check("async rst sfp_tx_disable", 32'(tx_dis), 32'd1);
    check("async rst led", 32'(led), 32'd0);
    check("async rst gpio_p", 32'(gpio_p), 32'd0);
    check("async rst gpio_n", 32'(gpio_n), 32'd1);
  endtask

  task automatic sat_test();
    logic [15:0] cnt;
    s_rst_n = 1'b0; s_dipsw = 4'b0000; s_force = 1'b0; s_btn = 1'b0;
    cyc(3);
    s_rst_n = 1'b1;
    wait_led0(1'b1, 1'b1, 60, "sat instance lock");
    s_force = 1'b1;
    cyc(65600);
    check("sat lock held", 32'(s_led[0]), 32'd1);
    s_dipsw[0] = 1'b1;
    cyc(3);
    check("disabled sfp_tx_disable", 32'(s_tx_dis), 32'd1);
    check("disabled txp", 32'(s_txp), 32'd0);
    check("disabled led2", 32'(s_led[2]), 32'd0);
    read_cnt(1'b1, cnt);
    check("counter saturated", 32'(cnt), 32'h0000FFFF);
    check("sat sticky", 32'(s_led[1]), 32'd1);
  endtask

  initial begin
    fork
      main_test();
      sat_test();
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
